// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FWFT FIFO of {pc, inst}.
// Flush clears the queue on a taken branch/jump; empty head reads as pc 0 / NOP.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_inst,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_inst,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign o_full      = (count == CW'(DEPTH));
    assign o_empty     = (count == '0);
    assign o_in_ready  = ~o_full;
    // Flush masks valid combinationally so decode never consumes a dying entry.
    assign o_out_valid = ~o_empty & ~i_flush;
    assign o_count     = count;

    assign push = i_in_valid & o_in_ready & ~i_flush;
    assign pop  = o_out_valid & i_out_ready & ~i_flush;

    always_comb begin
        o_pc   = '0;
        o_inst = NOP;
        if (!o_empty) begin
            o_pc   = mem[rd_ptr][63:32];
            o_inst = mem[rd_ptr][31:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && push) begin
            mem[wr_ptr] <= {i_pc, i_inst};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model plus a hand-written vector table.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_flush;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q[$];
    logic        m_push;
    logic        m_pop;

    fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_pc        (i_pc),
        .i_inst      (i_inst),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_pc        (o_pc),
        .o_inst      (o_inst),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic [2:0]  e_count;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vector_t;

    vector_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rst_n, input logic fl, input logic iv,
                          input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
        i_reset     = rst_n;
        i_flush     = fl;
        i_in_valid  = iv;
        i_pc        = pc;
        i_inst      = inst;
        i_out_ready = ordy;
    endtask

    // Called at the negedge: compare DUT against the model, then advance one edge.
    task automatic finish_cycle();
        logic [63:0] head;
        int unsigned sz;
        sz   = q.size();
        head = (sz != 0) ? q[0] : {32'h0, NOP};
        chk("in_ready",  32'(o_in_ready),  32'(sz < DEPTH));
        chk("out_valid", 32'(o_out_valid), 32'((sz != 0) && !i_flush));
        chk("count",     32'(o_count),     32'(sz));
        chk("full",      32'(o_full),      32'(sz == DEPTH));
        chk("empty",     32'(o_empty),     32'(sz == 0));
        chk("head_pc",   o_pc,             head[63:32]);
        chk("head_inst", o_inst,           head[31:0]);
        m_push = i_in_valid && (sz < DEPTH) && !i_flush;
        m_pop  = (sz != 0) && !i_flush && i_out_ready;
        if (o_out_valid && i_out_ready) begin
            chk("pop_allowed", 32'(m_pop), 32'd1);
            if (m_pop) chk("pop_pc", o_pc, head[63:32]);
        end
        @(posedge i_clk);
        if (!i_reset || i_flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back({i_pc, i_inst});
        end
        #1;
    endtask

    initial begin
        int seen;

        tbl[0]  = '{1'b1, 32'h00, 32'h00100093, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00, NOP};
        tbl[1]  = '{1'b1, 32'h04, 32'h00200113, 1'b0, 3'd1, 1'b1, 1'b1, 32'h00, 32'h00100093};
        tbl[2]  = '{1'b1, 32'h08, 32'h00300193, 1'b0, 3'd2, 1'b1, 1'b1, 32'h00, 32'h00100093};
        tbl[3]  = '{1'b0, 32'h00, 32'h00000000, 1'b0, 3'd3, 1'b1, 1'b1, 32'h00, 32'h00100093};
        tbl[4]  = '{1'b1, 32'h0C, 32'h00400213, 1'b0, 3'd3, 1'b1, 1'b1, 32'h00, 32'h00100093};
        tbl[5]  = '{1'b1, 32'h10, 32'h00500293, 1'b0, 3'd4, 1'b1, 1'b0, 32'h00, 32'h00100093};
        tbl[6]  = '{1'b0, 32'h00, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b0, 32'h00, 32'h00100093};
        tbl[7]  = '{1'b0, 32'h00, 32'h00000000, 1'b0, 3'd3, 1'b1, 1'b1, 32'h04, 32'h00200113};
        tbl[8]  = '{1'b0, 32'h00, 32'h00000000, 1'b1, 3'd3, 1'b1, 1'b1, 32'h04, 32'h00200113};
        tbl[9]  = '{1'b0, 32'h00, 32'h00000000, 1'b1, 3'd2, 1'b1, 1'b1, 32'h08, 32'h00300193};
        tbl[10] = '{1'b0, 32'h00, 32'h00000000, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0C, 32'h00400213};
        tbl[11] = '{1'b0, 32'h00, 32'h00000000, 1'b1, 3'd0, 1'b0, 1'b1, 32'h00, NOP};

        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;

        // Reset state, then fill / overflow / drain from the table.
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b0, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy);
            @(negedge i_clk);
            chk($sformatf("tbl%0d_count", i), 32'(o_count),     32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_valid", i), 32'(o_out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(o_in_ready),  32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_pc", i),    o_pc,             tbl[i].e_pc);
            chk($sformatf("tbl%0d_inst", i),  o_inst,           tbl[i].e_inst);
            finish_cycle();
        end

        // Streaming: 12 entries through with push and pop every cycle.
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h10000000 | 32'(i), 1'b1);
            @(negedge i_clk);
            if (i > 0) chk("stream_count", 32'(o_count), 32'd1);
            if (o_out_valid) begin
                chk("stream_order", o_pc, 32'(seen * 4));
                seen++;
            end
            finish_cycle();
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge i_clk);
        if (o_out_valid) begin
            chk("stream_order", o_pc, 32'(seen * 4));
            seen++;
        end
        finish_cycle();
        chk("stream_total", 32'(seen), 32'd12);

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'h00A00013, 1'b0);
            @(negedge i_clk);
            finish_cycle();
        end
        set_in(1'b1, 1'b1, 1'b1, 32'h40, 32'h00B00013, 1'b1);
        @(negedge i_clk);
        chk("flush_valid_mask", 32'(o_out_valid), 32'd0);
        finish_cycle();
        set_in(1'b1, 1'b0, 1'b1, 32'h80, 32'h00C00013, 1'b0);
        @(negedge i_clk);
        chk("flush_empty", 32'(o_empty), 32'd1);
        chk("flush_nop",   o_inst,       NOP);
        finish_cycle();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        chk("post_flush_pc", o_pc, 32'h80);
        finish_cycle();

        // Reset mid-operation with push and pop active.
        set_in(1'b1, 1'b0, 1'b1, 32'h84, 32'h00D00013, 1'b0);
        @(negedge i_clk);
        finish_cycle();
        set_in(1'b0, 1'b0, 1'b1, 32'h88, 32'h00E00013, 1'b1);
        @(negedge i_clk);
        chk("pre_reset_count", 32'(o_count), 32'd2);
        finish_cycle();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        chk("reset_count", 32'(o_count), 32'd0);
        chk("reset_pc",    o_pc,         32'h0);
        chk("reset_inst",  o_inst,       NOP);
        finish_cycle();

        // Push into empty queue with decode ready: one-cycle latency, no bypass.
        set_in(1'b1, 1'b0, 1'b1, 32'h200, 32'h00F00013, 1'b1);
        @(negedge i_clk);
        chk("nobypass_valid", 32'(o_out_valid), 32'd0);
        finish_cycle();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge i_clk);
        chk("latency_valid", 32'(o_out_valid), 32'd1);
        chk("latency_pc",    o_pc,             32'h200);
        finish_cycle();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        finish_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
